// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised LFSR generator.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_STREAM = 2'd2
    } lfsr_state_e;

    localparam int unsigned MODE_FIB = 0;
    localparam int unsigned MODE_GAL = 1;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-value function for a Fibonacci or Galois LFSR.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH = 8,
    parameter logic [WIDTH-1:0]    TAPS  = WIDTH'(8'h1D),
    parameter int unsigned         MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next_c
);

    // Galois toggles the tap mask when the bit shifted out is set.
    always_comb begin
        if (MODE == MODE_GAL) begin
            o_next_c = {1'b0, i_state[WIDTH-1:1]} ^ (i_state[0] ? TAPS : '0);
        end else begin
            o_next_c = {^(i_state & TAPS), i_state[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR sequence generator with seed load, single step, burst and stream
// modes, plus measurement of the sequence period since the last load.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned         WIDTH    = 8,
    parameter logic [WIDTH-1:0]    TAPS     = WIDTH'(8'h1D),
    parameter int unsigned         MODE     = MODE_FIB,
    parameter logic [WIDTH-1:0]    SEED_RST = WIDTH'(8'h01),
    parameter int unsigned         CW       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_step,
    input  logic             i_burst_start,
    input  logic [CW-1:0]    i_burst_len,
    input  logic             i_stream_en,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_state_q,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_burst_done,
    output logic             o_seed_fixed,
    output logic             o_period_wrap,
    output logic [WIDTH-1:0] o_period_len
);

    lfsr_state_e      r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_plen;
    logic             r_len_set;
    logic [CW-1:0]    r_rem;
    logic             r_busy;
    logic             r_valid;
    logic             r_burst_done;
    logic             r_seed_fixed;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic             w_adv;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .i_state  (r_lfsr),
        .o_next_c (w_next)
    );

    // In IDLE a step only counts when nothing of higher priority is requested.
    always_comb begin
        w_adv = 1'b0;
        case (r_state)
            ST_IDLE:   w_adv = i_step && !i_burst_start && !i_stream_en;
            ST_BURST:  w_adv = 1'b1;
            ST_STREAM: w_adv = r_valid && i_out_ready;
            default:   w_adv = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= SEED_RST;
            r_ref        <= SEED_RST;
            r_cnt        <= '0;
            r_plen       <= '0;
            r_len_set    <= 1'b0;
            r_rem        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_burst_done <= 1'b0;
            r_seed_fixed <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            r_seed_fixed <= 1'b0;
            r_wrap       <= 1'b0;
            if (i_load) begin
                r_lfsr       <= (i_seed == '0) ? SEED_RST : i_seed;
                r_ref        <= (i_seed == '0) ? SEED_RST : i_seed;
                r_seed_fixed <= (i_seed == '0);
                r_cnt        <= '0;
                r_plen       <= '0;
                r_len_set    <= 1'b0;
                r_rem        <= '0;
                r_busy       <= 1'b0;
                r_valid      <= 1'b0;
                r_state      <= ST_IDLE;
            end else begin
                if (w_adv) begin
                    r_lfsr <= w_next;
                    // Only the first return to the loaded value defines the period.
                    if (w_next == r_ref) begin
                        r_wrap <= 1'b1;
                        r_cnt  <= '0;
                        if (!r_len_set) begin
                            r_plen    <= r_cnt + WIDTH'(1);
                            r_len_set <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                case (r_state)
                    ST_IDLE: begin
                        if (i_burst_start) begin
                            if (i_burst_len == '0) begin
                                r_burst_done <= 1'b1;
                            end else begin
                                r_rem   <= i_burst_len;
                                r_busy  <= 1'b1;
                                r_state <= ST_BURST;
                            end
                        end else if (i_stream_en) begin
                            r_valid <= 1'b1;
                            r_state <= ST_STREAM;
                        end
                    end
                    ST_BURST: begin
                        r_rem <= r_rem - CW'(1);
                        if (r_rem == CW'(1)) begin
                            r_busy       <= 1'b0;
                            r_burst_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    ST_STREAM: begin
                        if (!i_stream_en) begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_state_q     = r_lfsr;
    assign o_out_valid   = r_valid;
    assign o_busy        = r_busy;
    assign o_burst_done  = r_burst_done;
    assign o_seed_fixed  = r_seed_fixed;
    assign o_period_wrap = r_wrap;
    assign o_period_len  = r_plen;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a Fibonacci (default) and a Galois (TAPS=B8) instance
// share stimulus and are checked against a sequence-level reference model.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_load;
    logic [7:0] i_seed;
    logic       i_step;
    logic       i_burst_start;
    logic [7:0] i_burst_len;
    logic       i_stream_en;
    logic       i_out_ready;

    logic [7:0] st   [2];
    logic       vld  [2];
    logic       bsy  [2];
    logic       bdone[2];
    logic       sfix [2];
    logic       wrap [2];
    logic [7:0] plen [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_st  [2];
    logic [7:0] m_ref [2];
    int         m_cnt [2];
    int         m_plen[2];
    bit         m_set [2];
    bit         m_wrap[2];

    always #5 clk = ~clk;

    lfsr_gen u_fib (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_seed(i_seed), .i_step(i_step),
        .i_burst_start(i_burst_start), .i_burst_len(i_burst_len),
        .i_stream_en(i_stream_en), .i_out_ready(i_out_ready),
        .o_state_q(st[0]), .o_out_valid(vld[0]), .o_busy(bsy[0]),
        .o_burst_done(bdone[0]), .o_seed_fixed(sfix[0]),
        .o_period_wrap(wrap[0]), .o_period_len(plen[0])
    );

    lfsr_gen #(.MODE(1), .TAPS(8'hB8)) u_gal (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_seed(i_seed), .i_step(i_step),
        .i_burst_start(i_burst_start), .i_burst_len(i_burst_len),
        .i_stream_en(i_stream_en), .i_out_ready(i_out_ready),
        .o_state_q(st[1]), .o_out_valid(vld[1]), .o_busy(bsy[1]),
        .o_burst_done(bdone[1]), .o_seed_fixed(sfix[1]),
        .o_period_wrap(wrap[1]), .o_period_len(plen[1])
    );

    // Reference next value: parity of tapped bits (Fibonacci) or
    // halve-and-toggle on odd values (Galois).
    function automatic logic [7:0] ref_next(input logic [7:0] r, input int d);
        int         ones;
        logic [7:0] taps;
        logic [7:0] n;
        taps = (d == 1) ? 8'hB8 : 8'h1D;
        n = r / 2;
        if (d == 1) begin
            if (r % 2 == 1) n = n ^ taps;
        end else begin
            ones = 0;
            for (int i = 0; i < 8; i++) if (r[i] && taps[i]) ones++;
            if (ones % 2 == 1) n = n + 8'd128;
        end
        return n;
    endfunction

    task automatic model_adv();
        logic [7:0] n;
        for (int d = 0; d < 2; d++) begin
            n = ref_next(m_st[d], d);
            m_wrap[d] = (n == m_ref[d]);
            if (m_wrap[d]) begin
                if (!m_set[d]) begin
                    m_plen[d] = m_cnt[d] + 1;
                    m_set[d]  = 1'b1;
                end
                m_cnt[d] = 0;
            end else begin
                m_cnt[d]++;
            end
            m_st[d] = n;
        end
    endtask

    task automatic model_idle();
        for (int d = 0; d < 2; d++) m_wrap[d] = 1'b0;
    endtask

    task automatic model_load(input logic [7:0] s);
        for (int d = 0; d < 2; d++) begin
            m_st[d]   = (s == 8'h00) ? 8'h01 : s;
            m_ref[d]  = m_st[d];
            m_cnt[d]  = 0;
            m_plen[d] = 0;
            m_set[d]  = 1'b0;
            m_wrap[d] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s);
        i_load = 1'b1;
        i_seed = s;
        tick();
        i_load = 1'b0;
        model_load(s);
    endtask

    task automatic run_burst(input logic [7:0] len, output int n);
        i_burst_start = 1'b1;
        i_burst_len   = len;
        tick();
        i_burst_start = 1'b0;
        n = 0;
        while (bsy[0] === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        for (int k = 0; k < int'(len); k++) model_adv();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_load = 0; i_seed = 0; i_step = 0; i_burst_start = 0;
        i_burst_len = 0; i_stream_en = 0; i_out_ready = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model_load(8'h01);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (st[d] !== 8'h01) begin failures++; $display("FAIL reset_state dut%0d got %h want 01", d, st[d]); end
            checks++;
            if ({vld[d], bsy[d], bdone[d], sfix[d], wrap[d]} !== 5'b0) begin
                failures++; $display("FAIL reset_flags dut%0d got %b want 00000", d, {vld[d], bsy[d], bdone[d], sfix[d], wrap[d]});
            end
            checks++;
            if (plen[d] !== 8'h00) begin failures++; $display("FAIL reset_plen dut%0d got %h want 00", d, plen[d]); end
        end
    endtask

    task automatic test_step();
        logic [7:0] exp_fib[5];
        int         n;
        bit         s;
        exp_fib = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        do_load(8'h01);
        for (int k = 0; k < 5; k++) begin
            i_step = 1'b1;
            tick();
            model_adv();
            checks++;
            if (st[0] !== exp_fib[k]) begin failures++; $display("FAIL fib_step%0d got %h want %h", k, st[0], exp_fib[k]); end
            checks++;
            if (st[1] !== m_st[1]) begin failures++; $display("FAIL gal_step%0d got %h want %h", k, st[1], m_st[1]); end
            if (k == 0) begin
                checks++;
                if (st[1] !== 8'hB8) begin failures++; $display("FAIL gal_first_step got %h want b8", st[1]); end
            end
        end
        i_step = 1'b0;
        for (int r = 0; r < 4; r++) begin
            do_load(8'($urandom_range(255, 1)));
            n = $urandom_range(30, 5);
            for (int k = 0; k < n; k++) begin
                s = 1'($urandom % 2);
                i_step = s;
                tick();
                if (s) model_adv(); else model_idle();
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (st[d] !== m_st[d] || wrap[d] !== m_wrap[d]) begin
                        failures++;
                        $display("FAIL rand_step dut%0d state/wrap got %h/%b want %h/%b", d, st[d], wrap[d], m_st[d], m_wrap[d]);
                    end
                end
            end
            i_step = 1'b0;
        end
    endtask

    task automatic test_zero_seed();
        do_load(8'h00);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (st[d] !== 8'h01 || sfix[d] !== 1'b1) begin
                failures++; $display("FAIL zero_seed dut%0d state/fix got %h/%b want 01/1", d, st[d], sfix[d]);
            end
        end
        tick();
        checks++;
        if (sfix[0] !== 1'b0) begin failures++; $display("FAIL seed_fixed_pulse got %b want 0", sfix[0]); end
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        model_adv();
        checks++;
        if (st[0] !== 8'h80) begin failures++; $display("FAIL zero_seed_step got %h want 80", st[0]); end
    endtask

    task automatic test_burst();
        int         n;
        logic [7:0] len;
        logic [7:0] hold;
        do_load(8'h01);
        for (int pass = 0; pass < 2; pass++) begin
            run_burst(8'd255, n);
            checks++;
            if (n != 255) begin failures++; $display("FAIL burst_busy_cycles got %0d want 255", n); end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (st[d] !== 8'h01 || wrap[d] !== 1'b1 || bdone[d] !== 1'b1) begin
                    failures++;
                    $display("FAIL burst_end dut%0d state/wrap/done got %h/%b/%b want 01/1/1", d, st[d], wrap[d], bdone[d]);
                end
                checks++;
                if (plen[d] !== 8'd255 || int'(plen[d]) != m_plen[d]) begin
                    failures++; $display("FAIL period_len dut%0d got %0d want 255", d, plen[d]);
                end
            end
            tick();
            checks++;
            if (bdone[0] !== 1'b0 || wrap[0] !== 1'b0) begin
                failures++; $display("FAIL burst_pulse_width done/wrap got %b/%b want 0/0", bdone[0], wrap[0]);
            end
        end
        hold = st[0];
        run_burst(8'd0, n);
        checks++;
        if (bdone[0] !== 1'b1 || bsy[0] !== 1'b0 || st[0] !== hold) begin
            failures++; $display("FAIL burst_zero done/busy/state got %b/%b/%h want 1/0/%h", bdone[0], bsy[0], st[0], hold);
        end
        for (int r = 0; r < 3; r++) begin
            do_load(8'($urandom_range(255, 1)));
            len = 8'($urandom_range(60, 1));
            run_burst(len, n);
            checks++;
            if (n != int'(len)) begin failures++; $display("FAIL rand_burst_cycles got %0d want %0d", n, len); end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (st[d] !== m_st[d] || bdone[d] !== 1'b1 || int'(plen[d]) != m_plen[d]) begin
                    failures++;
                    $display("FAIL rand_burst dut%0d state/done/plen got %h/%b/%0d want %h/1/%0d", d, st[d], bdone[d], plen[d], m_st[d], m_plen[d]);
                end
            end
        end
    endtask

    task automatic test_stream();
        bit         pat[4];
        bit         rdy;
        logic [7:0] s;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_load(8'($urandom_range(255, 1)));
        i_stream_en = 1'b1;
        tick();
        checks++;
        if (vld[0] !== 1'b1 || vld[1] !== 1'b1 || st[0] !== m_st[0]) begin
            failures++; $display("FAIL stream_enter valid/state got %b/%h want 1/%h", vld[0], st[0], m_st[0]);
        end
        for (int k = 0; k < 20; k++) begin
            rdy = (k < 4) ? pat[k] : 1'($urandom % 2);
            i_out_ready = rdy;
            tick();
            if (rdy) model_adv(); else model_idle();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (st[d] !== m_st[d]) begin failures++; $display("FAIL stream_hs%0d dut%0d got %h want %h", k, d, st[d], m_st[d]); end
            end
        end
        i_stream_en = 1'b0;
        i_out_ready = 1'b1;
        tick();
        model_adv();
        checks++;
        if (vld[0] !== 1'b0 || st[0] !== m_st[0] || st[1] !== m_st[1]) begin
            failures++; $display("FAIL stream_exit valid/state got %b/%h want 0/%h", vld[0], st[0], m_st[0]);
        end
        tick();
        checks++;
        if (st[0] !== m_st[0]) begin failures++; $display("FAIL idle_after_stream got %h want %h", st[0], m_st[0]); end
        i_out_ready = 1'b0;
        i_stream_en = 1'b1;
        repeat (2) tick();
        s = 8'($urandom_range(255, 1));
        i_stream_en = 1'b0;
        do_load(s);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vld[d] !== 1'b0 || st[d] !== s) begin
                failures++; $display("FAIL stream_load dut%0d valid/state got %b/%h want 0/%h", d, vld[d], st[d], s);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        do_load(8'h01);
        i_burst_start = 1'b1;
        i_burst_len   = 8'd100;
        tick();
        i_burst_start = 1'b0;
        repeat (10) begin tick(); model_adv(); end
        checks++;
        if (st[0] !== m_st[0] || st[1] !== m_st[1]) begin
            failures++; $display("FAIL pre_reset_state got %h/%h want %h/%h", st[0], st[1], m_st[0], m_st[1]);
        end
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (st[d] !== 8'h01 || bsy[d] !== 1'b0 || plen[d] !== 8'h00) begin
                failures++; $display("FAIL mid_burst_reset dut%0d state/busy/plen got %h/%b/%h want 01/0/00", d, st[d], bsy[d], plen[d]);
            end
        end
        tick();
        rst_n = 1'b1;
        model_load(8'h01);
        seen = 0;
        repeat (20) begin
            tick();
            if (bdone[0] === 1'b1 || bdone[1] === 1'b1 || bsy[0] === 1'b1 || st[0] !== 8'h01) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL post_reset_quiet got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_zero_seed();
        test_burst();
        test_stream();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised pseudo-random sequence generator and the next generation of the team's fixed 8-bit LFSR demo block. It adds:
- configurable width, tap mask and Fibonacci/Galois mode;
- seed load with all-zero lock-up protection;
- single step, fixed-length burst, and valid/ready streaming;
- a period counter that measures the sequence length since the last load.

Its state output feeds the existing seven-segment display path or any downstream consumer.

Parameters:
WIDTH, 8, LFSR register width (>=3, <=32).
TAPS, 8'h1D, WIDTH-bit tap mask. Fibonacci: feedback taps. Galois: toggle mask.
MODE, 0, 0 = Fibonacci, 1 = Galois.
SEED_RST, 8'h01, non-zero value loaded at reset and substituted for a zero seed.
CW, 8, burst_len width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  load seed this cycle
seed  in  WIDTH  seed value
step  in  1  advance once (IDLE only)
burst_start  in  1  begin a burst of burst_len advances
burst_len  in  CW  burst length, sampled on burst_start
stream_en  in  1  enter/stay in streaming mode
out_ready  in  1  consumer accepts state_q
state_q  out  WIDTH  current LFSR value
out_valid  out  1  state_q valid for stream handshake
busy  out  1  burst in progress
burst_done  out  1  one-cycle pulse after the last burst advance
seed_fixed  out  1  one-cycle pulse: a zero seed was replaced by SEED_RST
period_wrap  out  1  one-cycle pulse: sequence returned to the loaded seed
period_len  out  WIDTH  advances between the last load and the first wrap

Behaviour:
- Reset (async, rst_n=0):
  - state_q=SEED_RST; seed register=SEED_RST; FSM=IDLE.
  - All counters, period_len and pulse outputs = 0.
- Advance function, r = state_q:
  - MODE 0: next = {^(r & TAPS), r[WIDTH-1:1]}.
  - MODE 1: next = {1'b0, r[WIDTH-1:1]} ^ (r[0] ? TAPS : 0).
- Priority per cycle: load > burst_start > stream > step.
- load (any state):
  - state_q <= seed, or SEED_RST if seed==0; in the zero-seed case seed_fixed pulses next cycle.
  - Captures the loaded value as the wrap reference; clears the advance counter and period_len; FSM -> IDLE.
  - Aborts a burst: no burst_done.
- FSM states and transitions:
  - IDLE:
    - step=1 advances once (1-cycle latency).
    - burst_start=1: burst_len sampled; if burst_len==0, burst_done pulses next cycle and there is no advance (stays IDLE); otherwise -> BURST.
    - stream_en=1 -> STREAM.
  - BURST:
    - busy=1; advances every cycle, burst_len times in total.
    - On the final advance -> IDLE, with burst_done=1 in the following cycle.
    - step, stream_en and burst_start are ignored.
  - STREAM:
    - out_valid=1; advances only on out_valid && out_ready.
    - state_q holds while out_ready=0.
    - stream_en=0 -> IDLE next cycle. out_valid drops in that cycle, and any handshake in the exit cycle still advances.
- Period tracking:
  - Each advance increments the WIDTH-bit advance counter.
  - If next == wrap reference: period_wrap pulses, period_len <= count+1, counter clears.
  - period_len updates only on the first wrap after a load; later wraps pulse only.
- Outputs are registered; no combinational input-to-output paths.
- Reset mid-burst or mid-stream: immediate return to reset values; no pulses.

Decomposition:
- Package lfsr_pkg holds:
  - FSM state encodings (IDLE=2'd0, BURST=2'd1, STREAM=2'd2);
  - MODE constants MODE_FIB=0, MODE_GAL=1.
- Sub-module lfsr_next: purely combinational next-value function (WIDTH, TAPS, MODE), instantiated once. lfsr_gen owns the FSM, counters and handshake.

Test Plan:
- Reset, then load seed=8'h01 and step x4 (defaults) -> state_q sequence 8'h80, 8'h40, 8'h20, 8'h10, then 8'h88 on a fifth step.
- Load seed=8'h00 -> state_q=8'h01, seed_fixed pulses once; a subsequent step gives 8'h80.
- Load 8'h01, burst_len=255 -> busy high for 255 cycles, then state_q=8'h01, period_wrap pulse, period_len=255, burst_done pulse the cycle after; burst_len=0 -> burst_done next cycle, state unchanged.
- STREAM with out_ready toggling 1,0,0,1 -> exactly 2 advances, state_q stable while out_ready=0; load mid-stream -> IDLE, seed loaded.
- MODE=1, TAPS=8'hB8, seed 8'h01, one step -> state_q=8'hB8; full burst of 255 -> period_len=255.
- Assert rst_n low mid-burst (after 10 advances) -> state_q=8'h01, busy=0, no burst_done after release.
